// File: rtl/usb_tx_sched.sv
// ---------------------------------------------------------------------------
// usb_tx_sched
// Sequencer/arbiter in front of usb_tx. Two requesters share the single TX
// packet engine:
//   - handshake port (ACK=1, NAK=2, STALL=3)
//   - command port   (DIDX=5, DPARAM=6, DDIDX=7)
// Each packet runs GRANT -> START -> WAITD -> REL -> GAP -> IDLE. A packet
// whose type is not legal for its port is granted (consumed) and then
// rejected with err. WAITD aborts with err after TMO_CYC cycles without fd.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   hs_req/hs_type/hs_gnt    handshake request, type, 1-cycle grant
//   cmd_req/cmd_type/cmd_data/cmd_gnt  command request, type, word, grant
//   tx_fs/tx_fd              frame start (level) / frame done (level)
//   tx_btype/tx_data_cmd     packet type / command word, registered
//   busy                     high whenever the sequencer is not IDLE
//   done                     1-cycle pulse on normal completion
//   err                      1-cycle pulse on timeout or illegal type
//
// Configuration macro: USB_TX_SCHED_RR_EN
//   defined   -> round-robin on ties (last winner remembered, reset = cmd)
//   undefined -> fixed priority, handshake over command
// ---------------------------------------------------------------------------
module usb_tx_sched #(
    parameter int GAP_CYC = 4,
    parameter int TMO_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_req,
    input  logic [3:0]  hs_type,
    output logic        hs_gnt,
    input  logic        cmd_req,
    input  logic [3:0]  cmd_type,
    input  logic [31:0] cmd_data,
    output logic        cmd_gnt,
    output logic        tx_fs,
    input  logic        tx_fd,
    output logic [3:0]  tx_btype,
    output logic [31:0] tx_data_cmd,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(TMO_CYC + 1);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAITD = 3'd3,
        S_REL   = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    function automatic logic f_hs_legal(input logic [3:0] t);
        return (t >= 4'd1) && (t <= 4'd3);
    endfunction

    function automatic logic f_cmd_legal(input logic [3:0] t);
        return (t >= 4'd5) && (t <= 4'd7);
    endfunction

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic [GW-1:0] r_gap, w_gap_nxt;
    logic          r_abort, w_abort_nxt;     // current packet ended by timeout
    logic          r_is_hs, w_is_hs_nxt;     // current packet came from hs port
    logic          r_hs_gnt, w_hs_gnt_nxt;
    logic          r_cmd_gnt, w_cmd_gnt_nxt;
    logic          r_tx_fs, w_fs_nxt;
    logic [3:0]    r_tx_btype, w_btype_nxt;
    logic [31:0]   r_tx_data_cmd, w_data_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_err, w_err_nxt;
    logic          w_pick_hs;

`ifdef USB_TX_SCHED_RR_EN
    logic          r_last_hs, w_last_hs_nxt;  // 1: hs won the previous grant

    // Round-robin pick: on a tie the port not served last wins
    always_comb begin
        w_pick_hs = hs_req & (~cmd_req | ~r_last_hs);
    end
`else
    // Fixed-priority pick: handshake always beats command
    always_comb begin
        w_pick_hs = hs_req;
    end
`endif

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_tmo_nxt     = r_tmo;
        w_gap_nxt     = r_gap;
        w_abort_nxt   = r_abort;
        w_is_hs_nxt   = r_is_hs;
        w_hs_gnt_nxt  = 1'b0;
        w_cmd_gnt_nxt = 1'b0;
        w_fs_nxt      = 1'b0;
        w_btype_nxt   = r_tx_btype;
        w_data_nxt    = r_tx_data_cmd;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
`ifdef USB_TX_SCHED_RR_EN
        w_last_hs_nxt = r_last_hs;
`endif
        case (r_state)
            S_IDLE: begin
                if (hs_req || cmd_req) begin
                    w_state_nxt = S_GRANT;
                    w_is_hs_nxt = w_pick_hs;
`ifdef USB_TX_SCHED_RR_EN
                    w_last_hs_nxt = w_pick_hs;
`endif
                    if (w_pick_hs) begin
                        w_hs_gnt_nxt = 1'b1;
                        w_btype_nxt  = hs_type;
                        w_data_nxt   = 32'h0000_0000;
                    end else begin
                        w_cmd_gnt_nxt = 1'b1;
                        w_btype_nxt   = cmd_type;
                        w_data_nxt    = cmd_data;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                // The request is already consumed; an illegal type only ends the packet
                if (r_is_hs ? f_hs_legal(r_tx_btype) : f_cmd_legal(r_tx_btype)) begin
                    w_state_nxt = S_START;
                    w_fs_nxt    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_START: begin
                w_state_nxt = S_WAITD;
                w_fs_nxt    = 1'b1;
                w_tmo_nxt   = '0;
                w_abort_nxt = 1'b0;
            end
            S_WAITD: begin
                // A stale fd also lands here; REL only finishes once fd falls
                if (tx_fd) begin
                    w_state_nxt = S_REL;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = S_REL;
                    w_err_nxt   = 1'b1;
                    w_abort_nxt = 1'b1;
                end else begin
                    w_fs_nxt  = 1'b1;
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            S_REL: begin
                if (!tx_fd) begin
                    w_done_nxt = ~r_abort;
                    w_gap_nxt  = '0;
                    if (GAP_CYC == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end else begin
                    w_state_nxt = S_REL;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + GW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tmo         <= '0;
            r_gap         <= '0;
            r_abort       <= 1'b0;
            r_is_hs       <= 1'b0;
            r_hs_gnt      <= 1'b0;
            r_cmd_gnt     <= 1'b0;
            r_tx_fs       <= 1'b0;
            r_tx_btype    <= 4'd0;
            r_tx_data_cmd <= 32'h0000_0000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
`ifdef USB_TX_SCHED_RR_EN
            r_last_hs     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_tmo         <= w_tmo_nxt;
            r_gap         <= w_gap_nxt;
            r_abort       <= w_abort_nxt;
            r_is_hs       <= w_is_hs_nxt;
            r_hs_gnt      <= w_hs_gnt_nxt;
            r_cmd_gnt     <= w_cmd_gnt_nxt;
            r_tx_fs       <= w_fs_nxt;
            r_tx_btype    <= w_btype_nxt;
            r_tx_data_cmd <= w_data_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
`ifdef USB_TX_SCHED_RR_EN
            r_last_hs     <= w_last_hs_nxt;
`endif
        end
    end

    assign hs_gnt      = r_hs_gnt;
    assign cmd_gnt     = r_cmd_gnt;
    assign tx_fs       = r_tx_fs;
    assign tx_btype    = r_tx_btype;
    assign tx_data_cmd = r_tx_data_cmd;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_usb_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_sched
// Drives usb_tx_sched with directed and $urandom packets and plays the usb_tx
// side (fd timing, stale fd, timeout). Expected grants, types, fs window,
// done/err pulses and gap length come from a packet-level model of the
// sequencer's rules. Inputs change and outputs are sampled on negedges.
// ---------------------------------------------------------------------------
module tb_usb_tx_sched;

    localparam int GAP = 4;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs_req;
    logic [3:0]  hs_type;
    logic        hs_gnt;
    logic        cmd_req;
    logic [3:0]  cmd_type;
    logic [31:0] cmd_data;
    logic        cmd_gnt;
    logic        tx_fs;
    logic        tx_fd;
    logic [3:0]  tx_btype;
    logic [31:0] tx_data_cmd;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    bit m_last_hs = 1'b0;   // model of the round-robin memory (reset = cmd)

    usb_tx_sched #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .hs_req(hs_req), .hs_type(hs_type), .hs_gnt(hs_gnt),
        .cmd_req(cmd_req), .cmd_type(cmd_type), .cmd_data(cmd_data), .cmd_gnt(cmd_gnt),
        .tx_fs(tx_fs), .tx_fd(tx_fd), .tx_btype(tx_btype), .tx_data_cmd(tx_data_cmd),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Serve one packet from the currently held requests. Entry: a negedge with
    // the DUT idle. Exit: the first negedge at which the DUT is idle again.
    // j: cycles after fs rises before fd rises; h: cycles fd stays high after
    // fs falls; tmo: never raise fd; stale: raise fd before fs rises.
    task automatic serve_one(input int j, input int h, input bit tmo, input bit stale);
        bit          win_hs;
        bit          legal;
        logic [3:0]  et;
        logic [31:0] ed;
        int          k;
        if (hs_req && cmd_req) begin
`ifdef USB_TX_SCHED_RR_EN
            win_hs = !m_last_hs;
`else
            win_hs = 1'b1;
`endif
        end else begin
            win_hs = hs_req;
        end
        m_last_hs = win_hs;
        et = win_hs ? hs_type : cmd_type;
        ed = win_hs ? 32'h0 : cmd_data;
        legal = win_hs ? (et inside {4'd1, 4'd2, 4'd3}) : (et inside {4'd5, 4'd6, 4'd7});

        @(negedge clk);   // GRANT
        check("hs_gnt", hs_gnt, win_hs);
        check("cmd_gnt", cmd_gnt, !win_hs);
        check("busy_grant", busy, 1);
        check("fs_grant", tx_fs, 0);
        check("btype_grant", tx_btype, et);
        check("data_grant", tx_data_cmd, ed);
        if (win_hs) hs_req = 1'b0; else cmd_req = 1'b0;
        if (stale && legal && !tmo) tx_fd = 1'b1;

        @(negedge clk);   // START, or IDLE after illegal type
        if (!legal) begin
            check("err_illegal", err, 1);
            check("fs_illegal", tx_fs, 0);
            check("busy_illegal", busy, 0);
            check("done_illegal", done, 0);
            return;
        end
        check("fs_start", tx_fs, 1);
        check("err_start", err, 0);

        if (tmo) begin
            for (int i = 0; i < TMO; i++) begin
                @(negedge clk);
                check("fs_waitd", tx_fs, 1);
                check("err_early", err, 0);
            end
            @(negedge clk);
            check("err_tmo", err, 1);
            check("fs_tmo", tx_fs, 0);
            check("done_tmo", done, 0);
        end else begin
            if (!stale && j == 0) tx_fd = 1'b1;
            k = (stale || j < 1) ? 1 : j;
            for (int i = 1; i <= k; i++) begin
                @(negedge clk);
                check("fs_hold", tx_fs, 1);
                check("btype_hold", tx_btype, et);
                check("data_hold", tx_data_cmd, ed);
                check("done_early", done, 0);
                check("err_waitd", err, 0);
                if (!stale && i == j) tx_fd = 1'b1;
            end
            @(negedge clk);   // fs released
            check("fs_rel", tx_fs, 0);
            check("busy_rel", busy, 1);
            check("done_rel", done, 0);
            check("err_rel", err, 0);
        end

        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            check("done_fdhi", done, 0);
            check("data_rel", tx_data_cmd, ed);
            check("busy_fdhi", busy, 1);
        end
        tx_fd = 1'b0;
        @(negedge clk);   // first GAP cycle
        check("done_pulse", done, !tmo);
        check("err_gap", err, 0);
        check("busy_gap0", busy, GAP != 0);
        for (int i = 1; i <= GAP; i++) begin
            @(negedge clk);
            check("done_once", done, 0);
            check("gnt_in_gap", hs_gnt | cmd_gnt, 0);
            check("busy_gap", busy, i < GAP);
        end
    endtask

    task automatic serve_all(input int j, input int h, input bit stale);
        while (hs_req || cmd_req) serve_one(j, h, 1'b0, stale);
    endtask

    initial begin
        rst = 1'b0; hs_req = 1'b0; hs_type = 4'd0; cmd_req = 1'b0;
        cmd_type = 4'd0; cmd_data = 32'h0; tx_fd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_fs", tx_fs, 0);
        check("rst_gnt", {hs_gnt, cmd_gnt, done, err}, 0);
        check("rst_btype", tx_btype, 0);
        check("rst_data", tx_data_cmd, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // ACK handshake
        hs_req = 1'b1; hs_type = 4'd1;
        serve_all(3, 2, 1'b0);
        // DPARAM command
        cmd_req = 1'b1; cmd_type = 4'd6; cmd_data = 32'h3A5C_7000;
        serve_all(2, 1, 1'b0);
        // Repeated ties
        for (int t = 0; t < 3; t++) begin
            hs_req = 1'b1; hs_type = 4'd2;
            cmd_req = 1'b1; cmd_type = 4'd7; cmd_data = 32'hC0DE_0000 + 32'(t);
            serve_all(1, 0, 1'b0);
        end
        // Command timeout
        cmd_req = 1'b1; cmd_type = 4'd5; cmd_data = 32'h1234_5000;
        serve_one(0, 0, 1'b1, 1'b0);
        // Illegal handshake type, illegal command type
        hs_req = 1'b1; hs_type = 4'h5;
        serve_all(0, 0, 1'b0);
        cmd_req = 1'b1; cmd_type = 4'h1; cmd_data = 32'hFFFF_FFFF;
        serve_all(0, 0, 1'b0);
        // Stale fd
        hs_req = 1'b1; hs_type = 4'd3;
        serve_all(0, 1, 1'b1);

        // Reset while waiting for fd
        hs_req = 1'b1; hs_type = 4'd3;
        @(negedge clk);
        check("rst_t_gnt", hs_gnt, 1);
        hs_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_t_fs", tx_fs, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_last_hs = 1'b0;
        check("rst_t_fs0", tx_fs, 0);
        check("rst_t_busy", busy, 0);
        check("rst_t_flags", {done, err}, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_t_quiet", {busy, done, err, tx_fs}, 0);
        end
        cmd_req = 1'b1; cmd_type = 4'd7; cmd_data = 32'h5500_AA00;
        serve_all(1, 0, 1'b0);

        // Random packets
        for (int n = 0; n < 40; n++) begin
            bit a, b;
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (!a && !b) a = 1'b1;
            hs_req = a; cmd_req = b;
            hs_type = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
            cmd_type = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 7));
            cmd_data = $urandom;
            serve_all($urandom_range(0, 4), $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
